// File: rtl/rv32i_fetch_queue_pkg.sv
// Shared types and constants for the RV32I prefetch queue: the buffered
// {pc, inst} entry layout and the word-alignment helper for fetch addresses.
package rv32i_fetch_queue_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;
    localparam logic [PC_W-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/rv32i_sync_fifo.sv
// Synchronous FIFO with combinational head read, occupancy count and a
// single-cycle clear used to squash the queue on a redirect.
module rv32i_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             wr_fire, rd_fire;

    assign full    = (count_reg == CNT_DEPTH);
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;
    // Head is visible the cycle after it is written, with no extra read stage.
    assign rd_data = mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (wr_fire) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (rd_fire) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            count_reg <= count_reg + CW'(wr_fire) - CW'(rd_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_reg[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/rv32i_fetch_queue.sv
// RV32I prefetch stage: credit-limited pipelined fetch issue, in-order response
// capture into a {pc,inst} queue, and squashing of in-flight fetches on redirect.
module rv32i_fetch_queue
    import rv32i_fetch_queue_pkg::*;
#(
    parameter logic [31:0] PC_RESET = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_iaddr,
    output logic        o_stb_inst,
    input  logic        i_stall_inst,
    input  logic        i_ack_inst,
    input  logic [31:0] i_inst,
    input  logic        i_flush,
    input  logic [31:0] i_flush_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic        o_ce,
    input  logic        i_stall
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

    logic              stb_reg, stb_next;
    logic [31:0]       iaddr_reg, iaddr_next;
    logic [31:0]       ret_pc_reg, ret_pc_next;
    logic [CW-1:0]     outstanding_reg, outstanding_next;
    logic [CW-1:0]     drop_reg, drop_next;
    logic [CW-1:0]     occ, occ_next;
    logic [CW:0]       credits_next;
    logic              accept, keep, fifo_wr, fifo_rd;
    logic              fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] fifo_rd_data;
    fetch_entry_t      head, wr_entry;

    assign accept  = stb_reg && !i_stall_inst;
    assign keep    = i_ack_inst && (drop_reg == '0);
    // A redirect wins over both the kept ack and the decoder pop in the same cycle.
    assign fifo_wr = keep && !i_flush && !fifo_full;
    assign fifo_rd = !fifo_empty && !i_stall && !i_flush;

    assign wr_entry.pc   = ret_pc_reg;
    assign wr_entry.inst = i_inst;

    rv32i_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .clear   (i_flush),
        .wr_en   (fifo_wr),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .count   (occ),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        iaddr_next       = iaddr_reg;
        ret_pc_next      = ret_pc_reg;
        drop_next        = drop_reg;
        outstanding_next = outstanding_reg + CW'(accept) - CW'(i_ack_inst);
        occ_next         = occ + CW'(fifo_wr) - CW'(fifo_rd);
        if (i_flush) begin
            // Everything still in flight after this edge belongs to the old stream.
            drop_next   = outstanding_next;
            iaddr_next  = word_align(i_flush_pc);
            ret_pc_next = word_align(i_flush_pc);
            occ_next    = '0;
        end else begin
            if (accept) iaddr_next = iaddr_reg + PC_INC;
            if (keep) ret_pc_next = ret_pc_reg + PC_INC;
            if (i_ack_inst && (drop_reg != '0)) drop_next = drop_reg - CW'(1);
        end
        credits_next = {1'b0, occ_next} + {1'b0, outstanding_next};
        stb_next     = (credits_next < CREDIT_MAX) && !i_flush;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            stb_reg         <= 1'b0;
            iaddr_reg       <= word_align(PC_RESET);
            ret_pc_reg      <= word_align(PC_RESET);
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            stb_reg         <= stb_next;
            iaddr_reg       <= iaddr_next;
            ret_pc_reg      <= ret_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    assign head       = fifo_rd_data;
    assign o_iaddr    = iaddr_reg;
    assign o_stb_inst = stb_reg;
    assign o_ce       = !fifo_empty;
    // While empty the pc port shows the next address expected to return.
    assign o_pc       = fifo_empty ? ret_pc_reg : head.pc;
    assign o_inst     = fifo_empty ? '0 : head.inst;

endmodule
